// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
//   NUM_REQ-way round-robin arbiter with ownership hold.
//
//   A requester that wins arbitration keeps its grant for as long as it holds
//   its req bit. When the owner lets go, the arbiter spends one idle cycle
//   (the release bubble). The priority pointer then moves to the slot just
//   after the old owner, so every requester gets its turn.
//
//   Optional feature (compile-time macro ARBITER_HOLD_LIMIT_EN):
//     When defined, a hold counter limits ownership to MAX_HOLD cycles while
//     some other requester is waiting. With no contention, the owner keeps
//     the grant and the counter stays saturated. When the macro is undefined,
//     the counter is not built and MAX_HOLD only takes part in parameter
//     validation.
//
//   flush is a synchronous abort. It clears the grant and leaves the pointer
//   untouched. n_rst is an asynchronous active-low reset. It clears everything,
//   including the pointer.
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic                       clk,
    input  logic                       n_rst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic                       flush,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [$clog2(NUM_REQ)-1:0] gnt_idx,
    output logic                       busy
);

    localparam int IDX_W = $clog2(NUM_REQ);

`ifdef ARBITER_HOLD_LIMIT_EN
    localparam int CNT_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);
`endif

    // Elaboration-time sanity checks on the configuration.
    if (NUM_REQ < 2) begin : g_bad_num_req
        $error("rr_arbiter: NUM_REQ must be at least 2");
    end
    if (MAX_HOLD < 1) begin : g_bad_max_hold
        $error("rr_arbiter: MAX_HOLD must be at least 1");
    end

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_OWNED = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------

    // Bring a value in [0, 2*NUM_REQ-2] back into [0, NUM_REQ-1]. Every
    // operand is at most NUM_REQ-1, so a single conditional subtract is
    // enough. This also holds when NUM_REQ is not a power of two.
    function automatic logic [IDX_W-1:0] idx_wrap(input logic [IDX_W:0] v);
        logic [IDX_W:0] t;
        if (v >= (IDX_W+1)'(NUM_REQ)) begin
            t = v - (IDX_W+1)'(NUM_REQ);
        end else begin
            t = v;
        end
        return t[IDX_W-1:0];
    endfunction

    // Slot that follows idx in the circular order.
    function automatic logic [IDX_W-1:0] idx_next(input logic [IDX_W-1:0] idx);
        return idx_wrap({1'b0, idx} + {{IDX_W{1'b0}}, 1'b1});
    endfunction

    // One-hot decode of an index.
    function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [NUM_REQ-1:0] oh;
        oh      = {NUM_REQ{1'b0}};
        oh[idx] = 1'b1;
        return oh;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t           state_r;
    logic [IDX_W-1:0] ptr_r;
`ifdef ARBITER_HOLD_LIMIT_EN
    logic [CNT_W-1:0] hold_cnt_r;
`endif

    // ------------------------------------------------------------------
    // Combinational decisions
    // ------------------------------------------------------------------
    logic             found_s;
    logic [IDX_W-1:0] winner_s;
    logic [IDX_W:0]   cand_sum_s;
    logic [IDX_W-1:0] cand_s;
    logic             owner_req_s;
    logic             release_s;
`ifdef ARBITER_HOLD_LIMIT_EN
    logic             others_s;
    logic             hold_hit_s;
`endif

    // Circular priority search starting at ptr_r; the first set req bit wins.
    always_comb begin
        found_s    = 1'b0;
        winner_s   = {IDX_W{1'b0}};
        cand_sum_s = {(IDX_W+1){1'b0}};
        cand_s     = {IDX_W{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            cand_sum_s = {1'b0, ptr_r} + (IDX_W+1)'(i);
            cand_s     = idx_wrap(cand_sum_s);
            if (!found_s && req[cand_s]) begin
                found_s  = 1'b1;
                winner_s = cand_s;
            end else begin
                found_s  = found_s;
                winner_s = winner_s;
            end
        end
    end

    // Decide whether the current owner gives up the grant at the next edge.
    always_comb begin
        owner_req_s = req[gnt_idx];
`ifdef ARBITER_HOLD_LIMIT_EN
        others_s    = |(req & ~gnt);
        hold_hit_s  = (hold_cnt_r == HOLD_LAST) && others_s;
        release_s   = !owner_req_s || hold_hit_s;
`else
        release_s   = !owner_req_s;
`endif
    end

    // ------------------------------------------------------------------
    // Arbiter FSM with registered outputs
    // ------------------------------------------------------------------

    // Single-process FSM: grant issue, hold, release bubble and flush abort.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_r    <= ST_IDLE;
            ptr_r      <= {IDX_W{1'b0}};
            gnt        <= {NUM_REQ{1'b0}};
            gnt_idx    <= {IDX_W{1'b0}};
            busy       <= 1'b0;
`ifdef ARBITER_HOLD_LIMIT_EN
            hold_cnt_r <= {CNT_W{1'b0}};
`endif
        end else if (flush) begin
            // Abort: drop any grant, keep the pointer where it is.
            state_r    <= ST_IDLE;
            ptr_r      <= ptr_r;
            gnt        <= {NUM_REQ{1'b0}};
            gnt_idx    <= {IDX_W{1'b0}};
            busy       <= 1'b0;
`ifdef ARBITER_HOLD_LIMIT_EN
            hold_cnt_r <= {CNT_W{1'b0}};
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (found_s) begin
                        state_r <= ST_OWNED;
                        gnt     <= onehot(winner_s);
                        gnt_idx <= winner_s;
                        busy    <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                        gnt     <= {NUM_REQ{1'b0}};
                        gnt_idx <= {IDX_W{1'b0}};
                        busy    <= 1'b0;
                    end
                    ptr_r      <= ptr_r;
`ifdef ARBITER_HOLD_LIMIT_EN
                    hold_cnt_r <= {CNT_W{1'b0}};
`endif
                end

                ST_OWNED: begin
                    if (release_s) begin
                        // The release edge is always followed by one idle
                        // cycle. The old owner moves to the lowest priority.
                        state_r    <= ST_IDLE;
                        ptr_r      <= idx_next(gnt_idx);
                        gnt        <= {NUM_REQ{1'b0}};
                        gnt_idx    <= {IDX_W{1'b0}};
                        busy       <= 1'b0;
`ifdef ARBITER_HOLD_LIMIT_EN
                        hold_cnt_r <= {CNT_W{1'b0}};
`endif
                    end else begin
                        state_r <= ST_OWNED;
                        ptr_r   <= ptr_r;
                        gnt     <= gnt;
                        gnt_idx <= gnt_idx;
                        busy    <= 1'b1;
`ifdef ARBITER_HOLD_LIMIT_EN
                        // Saturate so an uncontended owner can keep holding.
                        if (hold_cnt_r != HOLD_LAST) begin
                            hold_cnt_r <= hold_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                        end else begin
                            hold_cnt_r <= hold_cnt_r;
                        end
`endif
                    end
                end

                default: begin
                    state_r    <= ST_IDLE;
                    ptr_r      <= {IDX_W{1'b0}};
                    gnt        <= {NUM_REQ{1'b0}};
                    gnt_idx    <= {IDX_W{1'b0}};
                    busy       <= 1'b0;
`ifdef ARBITER_HOLD_LIMIT_EN
                    hold_cnt_r <= {CNT_W{1'b0}};
`endif
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rr_arbiter
//   Directed, self-checking bench for rr_arbiter (NUM_REQ = 4, MAX_HOLD = 8).
//   Inputs change on the falling edge. Outputs are sampled on the falling edge
//   after each rising edge. The sequence of steps leaves the hidden priority
//   pointer at a known value, so every expected value is worked out by hand.
// -----------------------------------------------------------------------------
module tb_rr_arbiter;

    logic       clk;
    logic       n_rst;
    logic [3:0] req;
    logic       flush;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;

    rr_arbiter #(
        .NUM_REQ  (4),
        .MAX_HOLD (8)
    ) dut (
        .clk     (clk),
        .n_rst   (n_rst),
        .req     (req),
        .flush   (flush),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net: the run must never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // Compares one observed value with its expected value and counts the result.
    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Checks all three outputs. An idle arbiter must also show gnt_idx = 0.
    task automatic chk_out(input string tag, input logic [3:0] eg, input logic [1:0] ei,
                           input logic eb);
        chk({tag, ".gnt"},     {4'h0, gnt},     {4'h0, eg});
        chk({tag, ".gnt_idx"}, {6'h00, gnt_idx}, {6'h00, ei});
        chk({tag, ".busy"},    {7'h00, busy},   {7'h00, eb});
    endtask

    // Advances one clock and returns at the falling edge, ready to sample.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        n_rst = 1'b0;
        req   = 4'b0000;
        flush = 1'b0;

        // ---------------- reset, then idle ----------------
        @(negedge clk);
        chk_out("reset_low", 4'b0000, 2'd0, 1'b0);
        step();
        chk_out("reset_low2", 4'b0000, 2'd0, 1'b0);
        n_rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_out("idle_noreq", 4'b0000, 2'd0, 1'b0);
        end

        // ---------------- single request (ptr 0 -> 3) ----------------
        req = 4'b0100;
        step();
        chk_out("single_grant", 4'b0100, 2'd2, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step();
            chk_out("single_hold", 4'b0100, 2'd2, 1'b1);
        end
        req = 4'b0000;
        step();
        chk_out("single_release", 4'b0000, 2'd0, 1'b0);

        // ---------------- wrap search: ptr 3, req 0011 -> 0 ----------------
        req = 4'b0011;
        step();
        chk_out("wrap_grant", 4'b0001, 2'd0, 1'b1);
        req = 4'b0000;
        step();
        chk_out("wrap_release", 4'b0000, 2'd0, 1'b0);   // ptr now 1

        // ---------------- reset mid-grant ----------------
        req = 4'b1111;
        step();
        chk_out("pre_reset_grant", 4'b0010, 2'd1, 1'b1);
        n_rst = 1'b0;
        #1;
        chk_out("async_reset", 4'b0000, 2'd0, 1'b0);
        @(negedge clk);
        n_rst = 1'b1;                                   // ptr back to 0

        // ---------------- round-robin rotation 0,1,2,3,0 ----------------
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            logic [1:0] own;
            logic [3:0] oh;
            own = 2'(k % 4);
            oh  = 4'b0001 << own;
            step();
            chk_out("rr_grant", oh, own, 1'b1);
            step();
            chk_out("rr_hold", oh, own, 1'b1);
            req = 4'b1111 & ~oh;
            step();
            chk_out("rr_bubble", 4'b0000, 2'd0, 1'b0);
            req = 4'b1111;
        end
        req = 4'b0000;
        step();
        chk_out("rr_idle", 4'b0000, 2'd0, 1'b0);        // ptr = 1

        // ---------------- flush while owned ----------------
        req = 4'b1010;
        step();
        chk_out("flush_pre", 4'b0010, 2'd1, 1'b1);
        step();
        chk_out("flush_pre_hold", 4'b0010, 2'd1, 1'b1);
        flush = 1'b1;
        step();
        chk_out("flush_drop", 4'b0000, 2'd0, 1'b0);
        flush = 1'b0;
        step();
        chk_out("flush_regrant", 4'b0010, 2'd1, 1'b1);  // ptr kept at 1
        req = 4'b1000;
        step();
        chk_out("flush_rel", 4'b0000, 2'd0, 1'b0);      // ptr = 2
        step();
        chk_out("after_flush_grant3", 4'b1000, 2'd3, 1'b1);
        req = 4'b0000;
        step();
        chk_out("after_flush_rel3", 4'b0000, 2'd0, 1'b0); // ptr = 0

        // ---------------- flush in IDLE blocks a grant ----------------
        req   = 4'b0001;
        flush = 1'b1;
        step();
        chk_out("flush_idle_block", 4'b0000, 2'd0, 1'b0);
        flush = 1'b0;
        step();
        chk_out("flush_idle_grant", 4'b0001, 2'd0, 1'b1);

        // ---------------- uncontended long hold (any build) ----------------
        for (int i = 0; i < 12; i++) begin
            step();
            chk_out("solo_long_hold", 4'b0001, 2'd0, 1'b1);
        end
        req = 4'b0000;
        step();
        chk_out("solo_release", 4'b0000, 2'd0, 1'b0);   // ptr = 1

        // ---------------- contention 0011 from ptr 1 ----------------
        req = 4'b0011;
`ifdef ARBITER_HOLD_LIMIT_EN
        for (int r = 0; r < 3; r++) begin
            logic [1:0] own;
            own = (r % 2 == 0) ? 2'd1 : 2'd0;
            for (int c = 0; c < 8; c++) begin
                step();
                chk_out("hold_limit_own", 4'b0001 << own, own, 1'b1);
            end
            step();
            chk_out("hold_limit_bubble", 4'b0000, 2'd0, 1'b0);
        end
`else
        for (int c = 0; c < 20; c++) begin
            step();
            chk_out("no_limit_hold", 4'b0010, 2'd1, 1'b1);
        end
`endif
        req = 4'b0000;
        step();
        step();
        chk_out("final_idle", 4'b0000, 2'd0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
